hazard_detect_sb: RTL and testbench

- Parametrised successor to the decode-stage hazard detector.
- Tracks in-flight register writes with a per-register countdown scoreboard and raises data_hazard when the decode instruction reads a register still in flight.
- Generalised over register count, read-port count, writeback latency and number of control-hazard classes.
- Adds an optional forwarding mode in which only load/pop results stall, plus a flush input.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_scoreboard.sv | 56 +++++
 rtl/hazard_detect_sb.sv | 81 ++++++++
 tb/tb_hazard_detect_sb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and helpers for the scoreboard hazard detector.
`default_nettype none

package hazard_pkg;

  localparam int CTRL_CALL   = 0;
  localparam int CTRL_RET    = 1;
  localparam int CTRL_BRANCH = 2;

  function automatic int addr_width(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  function automatic int cnt_width(input int wb_lat, input int load_lat);
    int m;
    m = (wb_lat > load_lat) ? wb_lat : load_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Cycles a freshly accepted write keeps its destination busy.
  function automatic int lat_sel(input int forward_en, input int wb_lat,
                                 input int load_lat, input logic is_load);
    if (forward_en == 0) return wb_lat;
    return is_load ? load_lat : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register busy countdowns with WAW-safe reload and flush.
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_LK   = 2,
  parameter int CNT_W    = 3,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = addr_width(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [CNT_W-1:0]         wr_lat_i,
  input  logic [NUM_LK*ADDR_W-1:0] lk_addr_i,
  output logic [NUM_LK-1:0]        lk_busy_o,
  output logic [NUM_REGS-1:0]      busy_mask_o
);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] dec;
    logic             hit;

    // A rewrite of a busy register keeps whichever release time is later.
    always_comb begin
      dec   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      hit   = wr_en_i && (wr_addr_i == ADDR_W'(r)) && !((ZERO_REG != 0) && (r == 0));
      cnt_d = (hit && (wr_lat_i > dec)) ? wr_lat_i : dec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (flush_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy_mask_o[r] = (cnt_q != '0);
  end

  for (genvar p = 0; p < NUM_LK; p++) begin : g_lk
    assign lk_busy_o[p] = busy_mask_o[lk_addr_i[p*ADDR_W +: ADDR_W]];
  end

endmodule

`default_nettype wire

// File: rtl/hazard_detect_sb.sv
// hazard_detect_sb: decode-stage data/control hazard detector built on a countdown scoreboard.
`default_nettype none

module hazard_detect_sb
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int WB_LAT     = 4,
  parameter int LOAD_LAT   = 1,
  parameter int FORWARD_EN = 0,
  parameter int ZERO_REG   = 1,
  parameter int NUM_CTRL   = 3,
  localparam int ADDR_W    = addr_width(NUM_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  input  logic                     reg_write_i,
  input  logic                     is_load_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_CTRL-1:0]      ctrl_issue_i,
  input  logic [NUM_CTRL-1:0]      ctrl_clr_i,
  input  logic                     flush_i,
  output logic                     data_hazard_o,
  output logic                     control_hazard_o,
  output logic                     stall_o,
  output logic [NUM_REGS-1:0]      busy_mask_o
);

  localparam int CNT_W = cnt_width(WB_LAT, LOAD_LAT);

  logic [NUM_RD-1:0]   rd_busy;
  logic [NUM_RD-1:0]   port_hit;
  logic                accept;
  logic [CNT_W-1:0]    wr_lat;
  logic [NUM_CTRL-1:0] pend_q;
  logic [NUM_CTRL-1:0] pend_d;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_LK   (NUM_RD),
    .CNT_W    (CNT_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .wr_en_i     (accept & reg_write_i),
    .wr_addr_i   (wr_addr_i),
    .wr_lat_i    (wr_lat),
    .lk_addr_i   (rd_addr_i),
    .lk_busy_o   (rd_busy),
    .busy_mask_o (busy_mask_o)
  );

  assign port_hit         = {NUM_RD{issue_valid_i}} & rd_en_i & rd_busy;
  assign data_hazard_o    = |port_hit;
  assign control_hazard_o = |pend_q;
  assign stall_o          = data_hazard_o | control_hazard_o;
  assign accept           = issue_valid_i & ~stall_o;
  assign wr_lat           = CNT_W'(lat_sel(FORWARD_EN, WB_LAT, LOAD_LAT, is_load_i));

  // Set beats clear so a same-cycle issue/resolve of one class stays pending.
  assign pend_d = (pend_q & ~ctrl_clr_i) | (ctrl_issue_i & {NUM_CTRL{accept}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else if (flush_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_detect_sb.sv
// tb_hazard_detect_sb: vector table, directed corners and random run against a timestamp model.
`default_nettype none

module tb_hazard_detect_sb;
  import hazard_pkg::*;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, reg_write, is_load, flush;
  logic [4:0]  wr_addr;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [2:0]  ctrl_issue, ctrl_clr;
  logic [1:0]  dh, ch, st;
  logic [31:0] bm [2];

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_detect_sb u_def (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .reg_write_i(reg_write),
    .is_load_i(is_load), .wr_addr_i(wr_addr), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .ctrl_issue_i(ctrl_issue), .ctrl_clr_i(ctrl_clr), .flush_i(flush),
    .data_hazard_o(dh[0]), .control_hazard_o(ch[0]), .stall_o(st[0]), .busy_mask_o(bm[0])
  );

  hazard_detect_sb #(.FORWARD_EN(1), .LOAD_LAT(1)) u_fwd (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .reg_write_i(reg_write),
    .is_load_i(is_load), .wr_addr_i(wr_addr), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .ctrl_issue_i(ctrl_issue), .ctrl_clr_i(ctrl_clr), .flush_i(flush),
    .data_hazard_o(dh[1]), .control_hazard_o(ch[1]), .stall_o(st[1]), .busy_mask_o(bm[1])
  );

  // Model: each register remembers the last cycle in which a read of it must stall.
  longint     cyc;
  longint     rdy [2][NR];
  logic [2:0] pend [2];
  int         fwd_of [2] = '{0, 1};

  function automatic logic m_hit(input int d, input logic [4:0] a);
    return rdy[d][a] >= cyc;
  endfunction

  function automatic logic m_dh(input int d);
    logic [4:0] a0, a1;
    a0 = rd_addr[4:0];
    a1 = rd_addr[9:5];
    return issue_valid && ((rd_en[0] && m_hit(d, a0)) || (rd_en[1] && m_hit(d, a1)));
  endfunction

  function automatic logic m_ch(input int d);
    return |pend[d];
  endfunction

  function automatic logic [31:0] m_busy(input int d);
    logic [31:0] b;
    for (int r = 0; r < NR; r++) b[r] = (rdy[d][r] >= cyc);
    return b;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NR; r++) rdy[d][r] = -1;
      pend[d] = 3'b000;
    end
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        logic acc;
        longint l;
        acc = issue_valid && !(m_dh(d) || m_ch(d));
        if (flush) begin
          for (int r = 0; r < NR; r++) rdy[d][r] = -1;
          pend[d] = 3'b000;
        end else begin
          if (acc && reg_write && wr_addr != 5'd0) begin
            l = longint'(lat_sel(fwd_of[d], 4, 1, is_load));
            if (cyc + l > rdy[d][wr_addr]) rdy[d][wr_addr] = cyc + l;
          end
          pend[d] = (pend[d] & ~ctrl_clr) | (acc ? ctrl_issue : 3'b000);
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_dh%0d", d), 32'(dh[d]), 32'(m_dh(d)));
        chk($sformatf("model_ch%0d", d), 32'(ch[d]), 32'(m_ch(d)));
        chk($sformatf("model_stall%0d", d), 32'(st[d]), 32'(m_dh(d) | m_ch(d)));
        chk($sformatf("model_busy%0d", d), bm[d], m_busy(d));
      end
    end
  end

  typedef struct {
    logic        iv, rw, ld;
    logic [4:0]  wa;
    logic [1:0]  rden;
    logic [4:0]  ra0, ra1;
    logic [2:0]  ci, cc;
    logic        fl;
    logic        edh, ech;
    logic [31:0] ebusy;
  } vec_t;

  function automatic vec_t mk(input logic iv, rw, ld, input logic [4:0] wa,
                              input logic [1:0] rden, input logic [4:0] ra0, ra1,
                              input logic [2:0] ci, cc, input logic fl,
                              input logic edh, ech, input logic [31:0] ebusy);
    vec_t v;
    v.iv = iv; v.rw = rw; v.ld = ld; v.wa = wa; v.rden = rden; v.ra0 = ra0; v.ra1 = ra1;
    v.ci = ci; v.cc = cc; v.fl = fl; v.edh = edh; v.ech = ech; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    issue_valid = v.iv; reg_write = v.rw; is_load = v.ld; wr_addr = v.wa;
    rd_en = v.rden; rd_addr = {v.ra1, v.ra0};
    ctrl_issue = v.ci; ctrl_clr = v.cc; flush = v.fl;
  endtask

  // Drive one cycle's inputs just after the edge and return just after the falling edge.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1 apply(v);
    @(negedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t idle;
  vec_t rv;

  initial begin
    cyc = 0;
    model_clear();
    idle = mk(0,0,0,0, 2'b00,0,0, 3'b000,3'b000,0, 0,0,0);
    apply(idle);
    rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_dh%0d", d), 32'(dh[d]), 0);
      chk($sformatf("reset_ch%0d", d), 32'(ch[d]), 0);
      chk($sformatf("reset_stall%0d", d), 32'(st[d]), 0);
      chk($sformatf("reset_busy%0d", d), bm[d], 0);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    //                  iv rw ld wa  rden  ra0 ra1 ci      cc      fl dh ch busy
    tbl.push_back(mk(1,1,0, 2, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0, 0, 2'b01, 2, 0, 3'b000, 3'b000, 0, 1,0, 32'h4));
    tbl.push_back(mk(1,0,0, 0, 2'b01, 2, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,1,0, 1, 2'b01, 1, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0, 0, 2'b01, 1, 0, 3'b000, 3'b000, 0, 1,0, 32'h2));
    tbl.push_back(mk(1,1,0, 4, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,1,0, 3, 2'b01, 6, 0, 3'b000, 3'b000, 0, 0,0, 32'h10));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1,0,0, 0, 2'b10, 4, 4, 3'b000, 3'b000, 0, 1,0, 32'h18));
    tbl.push_back(mk(1,0,0, 0, 2'b10, 4, 4, 3'b000, 3'b000, 0, 0,0, 32'h08));
    tbl.push_back(mk(1,1,0, 7, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,0,0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h80));
    tbl.push_back(mk(1,1,0, 7, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h80));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 0, 1,0, 32'h80));
    tbl.push_back(mk(1,0,0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,0,0, 0, 2'b00, 0, 0, 3'b001, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(0,0,0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,1, 32'h0));
    tbl.push_back(mk(1,0,0, 0, 2'b00, 0, 0, 3'b100, 3'b000, 0, 0,1, 32'h0));
    tbl.push_back(mk(0,0,0, 0, 2'b00, 0, 0, 3'b000, 3'b001, 0, 0,1, 32'h0));
    tbl.push_back(mk(1,0,0, 0, 2'b00, 0, 0, 3'b100, 3'b100, 0, 0,0, 32'h0));
    tbl.push_back(mk(0,0,0, 0, 2'b00, 0, 0, 3'b000, 3'b001, 0, 0,1, 32'h0));
    tbl.push_back(mk(0,0,0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,1, 32'h0));
    tbl.push_back(mk(0,0,0, 0, 2'b00, 0, 0, 3'b000, 3'b100, 0, 0,1, 32'h0));
    tbl.push_back(mk(0,0,0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,1,0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,0,0, 0, 2'b11, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,1,0, 9, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,0,0, 0, 2'b01, 9, 0, 3'b000, 3'b000, 0, 1,0, 32'h200));
    tbl.push_back(mk(1,0,0, 0, 2'b01, 9, 0, 3'b000, 3'b000, 1, 1,0, 32'h200));
    tbl.push_back(mk(1,0,0, 0, 2'b01, 9, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));
    tbl.push_back(mk(1,1,0,10, 2'b00, 0, 0, 3'b010, 3'b000, 1, 0,0, 32'h0));
    tbl.push_back(mk(1,0,0, 0, 2'b01,10, 0, 3'b000, 3'b000, 0, 0,0, 32'h0));

    foreach (tbl[i]) begin
      step(tbl[i]);
      chk($sformatf("tbl%0d_dh", i), 32'(dh[0]), 32'(tbl[i].edh));
      chk($sformatf("tbl%0d_ch", i), 32'(ch[0]), 32'(tbl[i].ech));
      chk($sformatf("tbl%0d_stall", i), 32'(st[0]), 32'(tbl[i].edh | tbl[i].ech));
      chk($sformatf("tbl%0d_busy", i), bm[0], tbl[i].ebusy);
    end

    // Forwarding build: ALU results never stall, loads stall exactly one cycle.
    step(mk(1,1,0, 5, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 0));
    step(mk(1,0,0, 0, 2'b01, 5, 0, 3'b000, 3'b000, 0, 0,0, 0));
    chk("fwd_alu_dh", 32'(dh[1]), 0);
    chk("def_alu_dh", 32'(dh[0]), 1);
    repeat (4) step(idle);
    step(mk(1,1,1, 5, 2'b00, 0, 0, 3'b000, 3'b000, 0, 0,0, 0));
    step(mk(1,0,0, 0, 2'b01, 5, 0, 3'b000, 3'b000, 0, 0,0, 0));
    chk("fwd_load_dh1", 32'(dh[1]), 1);
    chk("fwd_load_busy", 32'(bm[1][5]), 1);
    step(mk(1,0,0, 0, 2'b01, 5, 0, 3'b000, 3'b000, 0, 0,0, 0));
    chk("fwd_load_dh2", 32'(dh[1]), 0);
    chk("def_load_dh", 32'(dh[0]), 1);

    // Asynchronous reset in the middle of a hazard window.
    rst_n = 1'b0;
    #1;
    chk("midrst_dh", 32'(dh[0]), 0);
    chk("midrst_stall", 32'(st[0]), 0);
    chk("midrst_busy", bm[0], 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      rv = idle;
      rv.iv   = ($urandom_range(0, 3) != 0);
      rv.rw   = $urandom_range(0, 1);
      rv.ld   = $urandom_range(0, 1);
      rv.wa   = 5'($urandom_range(0, 7));
      rv.rden = 2'($urandom_range(0, 3));
      rv.ra0  = 5'($urandom_range(0, 7));
      rv.ra1  = 5'($urandom_range(0, 7));
      rv.ci   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rv.cc   = 3'($urandom & $urandom);
      rv.fl   = ($urandom_range(0, 49) == 0);
      step(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
